// File: rtl/coax_rx_frame_ctrl.sv
// Receive-side framing for the 3270 coax decoder: checks each decoded word,
// groups words into frames by idle gap, and queues them on a valid/ready stream.
module coax_rx_frame_ctrl #(
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned GAP_TIMEOUT  = 1024,
  parameter int unsigned REARM_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] rxWord,
  input  logic        wordAvailable,
  output logic        rxReset,
  output logic [9:0]  outData,
  output logic        outErr,
  output logic        outLast,
  output logic        outValid,
  input  logic        outReady,
  output logic        frameEnd,
  output logic        overflow,
  input  logic        clearOverflow,
  output logic [7:0]  errCount
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned GW = $clog2(GAP_TIMEOUT);
  localparam int unsigned RW = (REARM_CYCLES > 1) ? $clog2(REARM_CYCLES) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STAGED = 2'd1;
  localparam logic [1:0] ST_REARM  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [9:0]    stage_data_q, stage_data_d;
  logic          stage_err_q, stage_err_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic [RW-1:0] rearm_cnt_q, rearm_cnt_d;
  logic          frame_end_q, frame_end_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    err_count_q, err_count_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [11:0]   mem_q [FIFO_DEPTH];

  logic        word_err;
  logic        load;
  logic        push;
  logic        push_last;
  logic        push_ok;
  logic        pop;
  logic [11:0] push_entry;
  logic [11:0] head;

  assign word_err = ~rxWord[11] | (^rxWord);

  // Framing FSM: a staged word is pushed only once we know whether it is last.
  always_comb begin
    state_d      = state_q;
    stage_data_d = stage_data_q;
    stage_err_d  = stage_err_q;
    gap_cnt_d    = gap_cnt_q;
    rearm_cnt_d  = rearm_cnt_q;
    err_count_d  = err_count_q;
    frame_end_d  = 1'b0;
    load         = 1'b0;
    push         = 1'b0;
    push_last    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wordAvailable) begin
          load    = 1'b1;
          state_d = ST_STAGED;
        end
      end
      ST_STAGED: begin
        if (wordAvailable) begin
          push = 1'b1;
          load = 1'b1;
        end else if (gap_cnt_q == GW'(GAP_TIMEOUT - 1)) begin
          push        = 1'b1;
          push_last   = 1'b1;
          frame_end_d = 1'b1;
          rearm_cnt_d = '0;
          state_d     = ST_REARM;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      ST_REARM: begin
        if (rearm_cnt_q == RW'(REARM_CYCLES - 1)) begin
          state_d = ST_IDLE;
        end else begin
          rearm_cnt_d = rearm_cnt_q + RW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (load) begin
      stage_data_d = rxWord[10:1];
      stage_err_d  = word_err;
      gap_cnt_d    = '0;
      if (word_err && (err_count_q != '1)) begin
        err_count_d = err_count_q + 8'd1;
      end
    end
  end

  assign push_entry = {push_last, stage_err_q, stage_data_q};

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  always_comb begin
    pop        = (count_q != '0) && outReady;
    push_ok    = push && ((count_q != CW'(FIFO_DEPTH)) || pop);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push_ok && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!push_ok && pop) begin
      count_d = count_q - CW'(1);
    end
    if (push && !push_ok) begin
      overflow_d = 1'b1;
    end else if (clearOverflow) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      stage_data_q <= '0;
      stage_err_q  <= 1'b0;
      gap_cnt_q    <= '0;
      rearm_cnt_q  <= '0;
      frame_end_q  <= 1'b0;
      overflow_q   <= 1'b0;
      err_count_q  <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      stage_data_q <= stage_data_d;
      stage_err_q  <= stage_err_d;
      gap_cnt_q    <= gap_cnt_d;
      rearm_cnt_q  <= rearm_cnt_d;
      frame_end_q  <= frame_end_d;
      overflow_q   <= overflow_d;
      err_count_q  <= err_count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

  // Storage is not reset, so the head fields are masked while the FIFO is empty.
  assign head     = mem_q[rd_ptr_q];
  assign outValid = (count_q != '0);
  assign outData  = outValid ? head[9:0] : '0;
  assign outErr   = outValid & head[10];
  assign outLast  = outValid & head[11];
  assign rxReset  = (state_q == ST_REARM);
  assign frameEnd = frame_end_q;
  assign overflow = overflow_q;
  assign errCount = err_count_q;

endmodule

// File: tb/tb_coax_rx_frame_ctrl.sv
// Directed bench for coax_rx_frame_ctrl with GAP_TIMEOUT=8, FIFO_DEPTH=4,
// REARM_CYCLES=2; expected values are hand-derived from the word format.
module tb_coax_rx_frame_ctrl;

  logic        clk;
  logic        reset;
  logic [11:0] rxWord;
  logic        wordAvailable;
  logic        rxReset;
  logic [9:0]  outData;
  logic        outErr;
  logic        outLast;
  logic        outValid;
  logic        outReady;
  logic        frameEnd;
  logic        overflow;
  logic        clearOverflow;
  logic [7:0]  errCount;

  int n_checks = 0;
  int n_errors = 0;
  int fe_cnt   = 0;
  int rxr_cnt  = 0;
  int fe_snap;
  int rxr_snap;

  coax_rx_frame_ctrl #(
    .FIFO_DEPTH  (4),
    .GAP_TIMEOUT (8),
    .REARM_CYCLES(2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rxWord       (rxWord),
    .wordAvailable(wordAvailable),
    .rxReset      (rxReset),
    .outData      (outData),
    .outErr       (outErr),
    .outLast      (outLast),
    .outValid     (outValid),
    .outReady     (outReady),
    .frameEnd     (frameEnd),
    .overflow     (overflow),
    .clearOverflow(clearOverflow),
    .errCount     (errCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frameEnd) fe_cnt++;
    if (rxReset) rxr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic strobe(input logic [11:0] w);
    rxWord        = w;
    wordAvailable = 1'b1;
    tick();
    wordAvailable = 1'b0;
    rxWord        = '0;
  endtask

  task automatic pop_check(input string tag, input logic [9:0] d, input logic e, input logic l);
    check({tag, "_valid"}, 32'(outValid), 32'd1);
    check({tag, "_data"}, 32'(outData), 32'(d));
    check({tag, "_err"}, 32'(outErr), 32'(e));
    check({tag, "_last"}, 32'(outLast), 32'(l));
    outReady = 1'b1;
    tick();
    outReady = 1'b0;
  endtask

  // Sync bit set, even parity over all 12 bits.
  function automatic logic [11:0] mk_word(input logic [9:0] d);
    logic [10:0] upper;
    upper = {1'b1, d};
    return {upper, ^upper};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset         = 1'b1;
    rxWord        = '0;
    wordAvailable = 1'b0;
    outReady      = 1'b0;
    clearOverflow = 1'b0;
    idle(2);
    reset = 1'b0;

    check("rst_valid", 32'(outValid), 32'd0);
    check("rst_rxreset", 32'(rxReset), 32'd0);
    check("rst_frameend", 32'(frameEnd), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_errcount", 32'(errCount), 32'd0);
    check("rst_data", 32'(outData), 32'd0);
    check("rst_err", 32'(outErr), 32'd0);
    check("rst_last", 32'(outLast), 32'd0);

    // Single word: push lands exactly 8 cycles after the strobe
    fe_snap  = fe_cnt;
    rxr_snap = rxr_cnt;
    strobe(12'hA55);
    idle(7);
    check("single_not_yet", 32'(outValid), 32'd0);
    tick();
    check("single_valid_at_8", 32'(outValid), 32'd1);
    check("single_frameend", 32'(frameEnd), 32'd1);
    check("single_rxreset", 32'(rxReset), 32'd1);
    tick();
    check("single_frameend_pulse", 32'(frameEnd), 32'd0);
    tick();
    check("single_rearm_done", 32'(rxReset), 32'd0);
    tick();
    check("single_fe_count", 32'(fe_cnt - fe_snap), 32'd1);
    check("single_rxr_count", 32'(rxr_cnt - rxr_snap), 32'd2);
    check("single_errcount", 32'(errCount), 32'd0);
    pop_check("single", 10'h12A, 1'b0, 1'b1);
    check("single_empty", 32'(outValid), 32'd0);

    // Three-word frame, 5 cycles apart
    strobe(12'h801);
    idle(4);
    strobe(12'hA55);
    idle(4);
    strobe(12'h803);
    idle(12);
    pop_check("three0", 10'h000, 1'b0, 1'b0);
    pop_check("three1", 10'h12A, 1'b0, 1'b0);
    pop_check("three2", 10'h001, 1'b1, 1'b1);
    check("three_empty", 32'(outValid), 32'd0);
    check("three_errcount", 32'(errCount), 32'd1);

    // Second word on the same cycle the timeout would fire
    fe_snap = fe_cnt;
    strobe(12'h801);
    idle(7);
    check("tie_no_push_yet", 32'(outValid), 32'd0);
    strobe(12'hA55);
    check("tie_no_frameend", 32'(frameEnd), 32'd0);
    check("tie_first_pushed", 32'(outValid), 32'd1);
    check("tie_first_last", 32'(outLast), 32'd0);
    idle(12);
    check("tie_fe_count", 32'(fe_cnt - fe_snap), 32'd1);
    pop_check("tie0", 10'h000, 1'b0, 1'b0);
    pop_check("tie1", 10'h12A, 1'b0, 1'b1);

    // Backpressure: six back-to-back words into a 4-deep FIFO
    for (int i = 0; i < 6; i++) begin
      strobe(mk_word(10'(10'h050 + i)));
      if (i >= 1) begin
        check($sformatf("bp_head_%0d", i), 32'(outData), 32'h050);
      end
    end
    check("bp_overflow_early", 32'(overflow), 32'd1);
    idle(12);
    check("bp_overflow", 32'(overflow), 32'd1);
    check("bp_head_end", 32'(outData), 32'h050);
    clearOverflow = 1'b1;
    tick();
    clearOverflow = 1'b0;
    check("bp_overflow_clr", 32'(overflow), 32'd0);
    for (int i = 0; i < 4; i++) begin
      pop_check($sformatf("bp_drain%0d", i), 10'(10'h050 + i), 1'b0, 1'b0);
    end
    check("bp_empty", 32'(outValid), 32'd0);
    check("bp_errcount", 32'(errCount), 32'd1);

    // Word strobed during rearm is ignored
    fe_snap = fe_cnt;
    strobe(12'hA55);
    idle(8);
    check("rearm_active", 32'(rxReset), 32'd1);
    strobe(12'h803);
    check("rearm_still", 32'(rxReset), 32'd1);
    tick();
    check("rearm_idle", 32'(rxReset), 32'd0);
    check("rearm_errcount", 32'(errCount), 32'd1);
    idle(12);
    pop_check("rearm_entry", 10'h12A, 1'b0, 1'b1);
    check("rearm_no_extra", 32'(outValid), 32'd0);
    check("rearm_fe_count", 32'(fe_cnt - fe_snap), 32'd1);

    // Reset with one word staged and two queued
    strobe(12'h801);
    strobe(12'hA55);
    strobe(12'h803);
    check("midrst_queued", 32'(outValid), 32'd1);
    fe_snap = fe_cnt;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_valid", 32'(outValid), 32'd0);
    check("midrst_frameend", 32'(frameEnd), 32'd0);
    check("midrst_errcount", 32'(errCount), 32'd0);
    idle(12);
    check("midrst_no_push", 32'(outValid), 32'd0);
    check("midrst_fe_count", 32'(fe_cnt - fe_snap), 32'd0);
    check("midrst_rxreset", 32'(rxReset), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/coax_rx_frame_ctrl.md
Name: coax_rx_frame_ctrl

Overview:
- Sits between the 3270 coax word decoder and the host-side logic.
- Consumes decoded 12-bit words, checks the sync bit and parity of each, and groups words into frames.
- A frame ends when no word arrives for a programmable number of clock cycles. At that point the block marks the last word and pulses the decoder's reset, so the decoder goes back to hunting for a header.
- Words are buffered in a FIFO and presented on a valid/ready stream with last and error flags.

Parameters:
- FIFO_DEPTH, 16, FIFO entries; must be a power of 2 and at least 2.
- GAP_TIMEOUT, 1024, idle clock cycles after a word that end the frame; must be at least 2.
- REARM_CYCLES, 4, cycles that rxReset is held high after a frame ends; must be at least 1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rxWord  in  12  decoded word from the decoder
- wordAvailable  in  1  single-cycle strobe; rxWord is valid in that cycle
- rxReset  out  1  reset to the decoder, used to re-arm header hunt
- outData  out  10  payload, equal to rxWord[10:1]
- outErr  out  1  word failed the sync or parity check
- outLast  out  1  word is the last word of its frame
- outValid  out  1  FIFO head is valid
- outReady  in  1  consumer accepts the head
- frameEnd  out  1  one-cycle pulse when a frame closes
- overflow  out  1  sticky: a push was dropped because the FIFO was full
- clearOverflow  in  1  clears overflow
- errCount  out  8  saturating count of error words

Behaviour:
- One clock. Reset is synchronous and active-high.
- Reset values:
  - FIFO empty, state IDLE.
  - outValid=0, rxReset=0, frameEnd=0, overflow=0, errCount=0.
  - outData, outErr and outLast are 0.
- Reset mid-frame discards the staged word and the FIFO contents; no frameEnd is produced.
- Word check: err = (rxWord[11]==0) OR (XOR of rxWord[11:0] != 0). The check is even parity over all 12 bits.
- Staging: each word is held in a stage register until it is known whether another word follows. The stage is then pushed with last=0 or last=1.
- IDLE state:
  - wordAvailable: load stage {data,err}, gapCnt=0, go to STAGED.
- STAGED state:
  - wordAvailable: push stage with last=0, load the new word, gapCnt=0. This takes priority over timeout in the same cycle.
  - Otherwise, if gapCnt==GAP_TIMEOUT-1: push stage with last=1, pulse frameEnd, rearmCnt=0, go to REARM.
  - Otherwise gapCnt increments.
- REARM state:
  - rxReset=1 for exactly REARM_CYCLES cycles, then go to IDLE with rxReset=0.
  - wordAvailable is ignored in this state.
- errCount increments, saturating at 255, when an erroneous word is loaded into the stage.
- FIFO entry is {last, err, data}. It is first-word-fall-through; outValid/outData/outErr/outLast reflect the head.
- Pop happens when outValid && outReady. The head must stay stable while outValid && !outReady.
- Push is accepted if count<FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the entry is dropped and overflow=1 from the next cycle.
  - overflow stays set until clearOverflow is asserted. If clearOverflow and a new drop occur in the same cycle, overflow stays set.
- Latency:
  - A word pushed in cycle N appears on outValid at N+1 if the FIFO was empty.
  - Timeout push occurs exactly GAP_TIMEOUT cycles after the last word's wordAvailable cycle.
- Empty pop is impossible, because outValid=0.
- Simultaneous push and pop at count 0 is legal. outValid rises the next cycle.

Test Plan:
- Parameters for all scenarios: GAP_TIMEOUT=8, FIFO_DEPTH=4, REARM_CYCLES=2.
- Single word: strobe rxWord=12'hA55, then idle.
  - Required: exactly 8 cycles later one entry is pushed with data=10'h12A, err=0, last=1.
  - frameEnd pulses once; rxReset is high for 2 cycles; errCount=0.
- Three-word frame: words 12'h801, 12'hA55, 12'h803, each 5 cycles apart.
  - Required: outputs data 0,0x12A,1 with last=0,0,1.
  - Word 3 (12'h803) has odd parity, so err=1 on the third entry only; errCount=1.
- Timeout tie: second word strobed on the same cycle the timeout would fire.
  - Required: no frameEnd at that point; the first entry has last=0.
- Backpressure/overflow: outReady=0, frame of 6 words.
  - Required: the first 4 entries are kept, overflow=1, and the head is stable throughout.
  - Assert clearOverflow: overflow returns to 0.
  - Raise outReady: the 4 entries drain in order.
- Rearm blocking: strobe wordAvailable during rxReset=1.
  - Required: the word is ignored, and the state is IDLE after 2 cycles.
- Reset mid-frame: assert reset with 1 word staged and 2 words queued.
  - Required: outValid=0 the next cycle, no frameEnd, errCount=0, and no push occurs afterwards.
